// File: rtl/nibble_serial_sub_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The master drives the operands and out_ready; the slave is the subtractor.
interface nibble_serial_sub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, busy
  );
endinterface

// File: rtl/nibble_serial_sub.sv
// Sequential D = A - B - BIN, one 4-bit borrow-lookahead slice per clock, LSB first.
// Define NSUB_SAT_EN to clamp the difference to zero when the final borrow is set.
module nibble_serial_sub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  nibble_serial_sub_if.slave  bus
);
  localparam int unsigned NS = WIDTH / 4;
  localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned IW = (WIDTH > 4) ? $clog2(WIDTH) : 2;

  if ((WIDTH % 4) != 0) begin : g_width_chk
    $error("nibble_serial_sub: WIDTH must be a multiple of 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic             br_q, bout_q;
  logic [CW-1:0]    cnt_q;

  logic [IW-1:0]    sidx;
  logic [3:0]       sa, sb, sg, sp, sdiff;
  logic [4:0]       sbr;
  logic             last;

  // Current slice: every borrow formed directly from g/p and the registered borrow-in
  always_comb begin
    sidx   = IW'({cnt_q, 2'b00});
    sa     = a_q[sidx +: 4];
    sb     = b_q[sidx +: 4];
    sg     = ~sa & sb;
    sp     = ~(sa ^ sb);
    sbr[0] = br_q;
    sbr[1] = sg[0] | (sp[0] & br_q);
    sbr[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & br_q);
    sbr[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
           | (sp[2] & sp[1] & sp[0] & br_q);
    sbr[4] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
           | (sp[3] & sp[2] & sp[1] & sg[0]) | (&sp & br_q);
    sdiff  = sa ^ sb ^ sbr[3:0];
    last   = (cnt_q == CW'(NS - 1));
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_RUN;
      S_RUN:   if (last)         state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, captured by the state register
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      S_IDLE:  in_ready_d  = 1'b1;
      S_RUN:   busy_d      = 1'b1;
      S_DONE: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: in_ready_d = 1'b1;
    endcase
  end

  // Operand capture and slice write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (state_q == S_IDLE && bus.in_valid) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        br_q  <= bus.bin;
        cnt_q <= '0;
      end else if (state_q == S_RUN) begin
        d_q[sidx +: 4] <= sdiff;
        br_q           <= sbr[4];
        cnt_q          <= cnt_q + CW'(1);
        if (last) begin
          bout_q <= sbr[4];
`ifdef NSUB_SAT_EN
          if (sbr[4]) d_q <= '0;
`else
`endif
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;
endmodule
